// File: rtl/ball_motion.sv
// Ball position/direction engine for the VGA game: per-tick stepping, wall and
// collision bounces, and the IDLE -> WAIT -> MOVE -> MISS serve/miss cycle.
module ball_motion #(
    parameter int COORD_W     = 10,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479,
    parameter int BALL_SIZE   = 8,
    parameter int X_INIT      = 316,
    parameter int Y_INIT      = 236,
    parameter int SPEED_W     = 3,
    parameter int SERVE_DELAY = 60
) (
    input  logic               iVGA_CLK,
    input  logic               iRST,
    input  logic               iTick,
    input  logic [3:0]         iCrash,
    input  logic [SPEED_W-1:0] iSpeed,
    input  logic               iServe,
    output logic [COORD_W-1:0] oBall_x,
    output logic [COORD_W-1:0] oBall_y,
    output logic               oDir_x,
    output logic               oDir_y,
    output logic [1:0]         oState,
    output logic               oMiss,
    output logic               oBounce
);

    localparam int AW    = COORD_W + 1;
    localparam int CNT_W = $clog2(SERVE_DELAY + 1);

    // One spare bit on every compare so x+step / y+step never wrap.
    localparam logic [AW-1:0]      XR_A    = AW'(X_MAX - BALL_SIZE + 1);
    localparam logic [AW-1:0]      YB_A    = AW'(Y_MAX - BALL_SIZE + 1);
    localparam logic [AW-1:0]      XMIN_A  = AW'(X_MIN);
    localparam logic [AW-1:0]      YMIN_A  = AW'(Y_MIN);
    localparam logic [COORD_W-1:0] XR_C    = COORD_W'(X_MAX - BALL_SIZE + 1);
    localparam logic [COORD_W-1:0] YB_C    = COORD_W'(Y_MAX - BALL_SIZE + 1);
    localparam logic [COORD_W-1:0] XMIN_C  = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] YMIN_C  = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] XINIT_C = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0] YINIT_C = COORD_W'(Y_INIT);
    localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(SERVE_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        MOVE = 2'd2,
        MISS = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [COORD_W-1:0] x, x_n, y, y_n;
    logic               dir_x, dir_x_n, dir_y, dir_y_n;
    logic [SPEED_W-1:0] step, step_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               miss, miss_n, bounce, bounce_n;

    logic               eff_x, eff_y;
    logic [AW-1:0]      x_a, y_a, step_a, x_sum, y_sum, x_dif, y_dif;

    always_comb begin
        state_n  = state;
        x_n      = x;
        y_n      = y;
        dir_x_n  = dir_x;
        dir_y_n  = dir_y;
        step_n   = step;
        cnt_n    = cnt;
        miss_n   = 1'b0;
        bounce_n = 1'b0;
        eff_x    = dir_x;
        eff_y    = dir_y;
        x_a      = {1'b0, x};
        y_a      = {1'b0, y};
        step_a   = AW'(step);
        x_sum    = x_a + step_a;
        y_sum    = y_a + step_a;
        x_dif    = x_a - step_a;
        y_dif    = y_a - step_a;

        case (state)
            IDLE: begin
                x_n = XINIT_C;
                y_n = YINIT_C;
                if (iServe) begin
                    step_n  = (iSpeed == '0) ? SPEED_W'(1) : iSpeed;
                    dir_x_n = 1'b0;
                    dir_y_n = 1'b1;
                    cnt_n   = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (iTick) begin
                    if (cnt == CNT_END) begin
                        cnt_n   = '0;
                        state_n = MOVE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            MOVE: begin
                // Crash flags only count when they oppose the current travel.
                if (!dir_x && iCrash[2])     eff_x = 1'b1;
                else if (dir_x && iCrash[3]) eff_x = 1'b0;
                if (!dir_y && iCrash[0])     eff_y = 1'b1;
                else if (dir_y && iCrash[1]) eff_y = 1'b0;
                dir_x_n = eff_x;
                dir_y_n = eff_y;

                if (iTick) begin
                    if (!eff_x) begin
                        if (x_sum >= XR_A) begin
                            x_n     = XR_C;
                            dir_x_n = 1'b1;
                        end else begin
                            x_n = x_sum[COORD_W-1:0];
                        end
                    end else begin
                        if (x_a < XMIN_A + step_a) begin
                            x_n     = XMIN_C;
                            dir_x_n = 1'b0;
                        end else begin
                            x_n = x_dif[COORD_W-1:0];
                        end
                    end

                    if (eff_y) begin
                        if (y_a < YMIN_A + step_a) begin
                            y_n     = YMIN_C;
                            dir_y_n = 1'b0;
                        end else begin
                            y_n = y_dif[COORD_W-1:0];
                        end
                    end else begin
                        // Falling past the bottom is a loss, not a bounce.
                        if (y_sum > YB_A) begin
                            y_n     = YB_C;
                            state_n = MISS;
                            miss_n  = 1'b1;
                        end else begin
                            y_n = y_sum[COORD_W-1:0];
                        end
                    end
                end
                bounce_n = (dir_x_n != dir_x) || (dir_y_n != dir_y);
            end
            MISS: begin
                state_n = IDLE;
                x_n     = XINIT_C;
                y_n     = YINIT_C;
                dir_x_n = 1'b0;
                dir_y_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            state  <= IDLE;
            x      <= XINIT_C;
            y      <= YINIT_C;
            dir_x  <= 1'b0;
            dir_y  <= 1'b1;
            step   <= SPEED_W'(1);
            cnt    <= '0;
            miss   <= 1'b0;
            bounce <= 1'b0;
        end else begin
            state  <= state_n;
            x      <= x_n;
            y      <= y_n;
            dir_x  <= dir_x_n;
            dir_y  <= dir_y_n;
            step   <= step_n;
            cnt    <= cnt_n;
            miss   <= miss_n;
            bounce <= bounce_n;
        end
    end

    assign oBall_x = x;
    assign oBall_y = y;
    assign oDir_x  = dir_x;
    assign oDir_y  = dir_y;
    assign oState  = state;
    assign oMiss   = miss;
    assign oBounce = bounce;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: serve latency, wall and crash bounces,
// miss handling, reset and ignored-serve cases with hand-computed positions.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] crash;
    logic [2:0] speed;
    logic       serve_req;
    logic [9:0] ball_x, ball_y;
    logic       dir_x, dir_y, miss, bounce;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ball_motion #(.SERVE_DELAY(4)) dut (
        .iVGA_CLK (clk),
        .iRST     (rst),
        .iTick    (tick),
        .iCrash   (crash),
        .iSpeed   (speed),
        .iServe   (serve_req),
        .oBall_x  (ball_x),
        .oBall_y  (ball_y),
        .oDir_x   (dir_x),
        .oDir_y   (dir_y),
        .oState   (state),
        .oMiss    (miss),
        .oBounce  (bounce)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs set before cyc() are captured at its edge; outputs read #1 later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
        end
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic do_serve(input int spd);
        speed     = 3'(spd);
        serve_req = 1'b1;
        cyc();
        serve_req = 1'b0;
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, "_x"}, int'(ball_x), ex);
        check({tag, "_y"}, int'(ball_y), ey);
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; crash = 4'b0; speed = 3'd0; serve_req = 1'b0;
        #2;

        // Reset state and ignored ticks in IDLE
        do_reset();
        check_pos("rst", 316, 236);
        check("rst_state", int'(state), 0);
        check("rst_miss", int'(miss), 0);
        check("rst_bounce", int'(bounce), 0);
        check("rst_dir_x", int'(dir_x), 0);
        check("rst_dir_y", int'(dir_y), 1);
        tick_n(5);
        check_pos("idle_tick", 316, 236);
        check("idle_state", int'(state), 0);

        // Serve with step 2: four delay ticks, then the first move
        do_serve(2);
        check("serve_state", int'(state), 1);
        tick_n(3);
        check("wait3_state", int'(state), 1);
        tick_n(1);
        check("wait4_state", int'(state), 2);
        check_pos("wait4", 316, 236);
        tick_n(1);
        check_pos("move1", 318, 234);

        // Right crash while moving right flips; again while moving left is ignored
        crash = 4'b0100;
        cyc();
        check("crash_r_dir", int'(dir_x), 1);
        check("crash_r_x", int'(ball_x), 318);
        check("crash_r_bounce", int'(bounce), 1);
        cyc();
        check("crash_r_ign_dir", int'(dir_x), 1);
        check("crash_r_ign_bounce", int'(bounce), 0);
        crash = 4'b0;

        // Travel up-left to y=20, then up crash with a tick steps downward
        tick_n(107);
        check_pos("pre_up", 104, 20);
        crash = 4'b0010;
        tick  = 1'b1;
        cyc();
        tick  = 1'b0;
        crash = 4'b0;
        check("crash_u_dir", int'(dir_y), 0);
        check_pos("crash_u", 102, 22);
        check("crash_u_bounce", int'(bounce), 1);

        // Serve during MOVE is ignored
        serve_req = 1'b1;
        cyc();
        serve_req = 1'b0;
        check("serve_move_state", int'(state), 2);
        check("serve_move_x", int'(ball_x), 102);

        // Reset during MOVE, together with a crash that would otherwise bounce
        crash = 4'b0001;
        rst   = 1'b1;
        cyc();
        rst   = 1'b0;
        crash = 4'b0;
        check_pos("rst_move", 316, 236);
        check("rst_move_state", int'(state), 0);
        check("rst_move_dir_y", int'(dir_y), 1);
        check("rst_move_bounce", int'(bounce), 0);

        // Step 4: top wall after 60 moves, right wall exactly on x+step == 632
        do_serve(4);
        tick_n(4);
        check("rw_state", int'(state), 2);
        tick_n(60);
        check_pos("top_wall", 556, 0);
        check("top_wall_dir_y", int'(dir_y), 0);
        tick_n(18);
        check_pos("rw_pre", 628, 72);
        check("rw_pre_dir", int'(dir_x), 0);
        tick_n(1);
        check_pos("rw_hit", 632, 76);
        check("rw_hit_dir", int'(dir_x), 1);
        check("rw_hit_bounce", int'(bounce), 1);
        cyc();
        check("rw_bounce_once", int'(bounce), 0);
        tick_n(1);
        check_pos("rw_back", 628, 80);

        // Step 6: turn downward by crash, fall from y=470 into the miss
        do_reset();
        do_serve(6);
        tick_n(4);
        crash = 4'b0010;
        cyc();
        crash = 4'b0;
        check("miss_turn_dir", int'(dir_y), 0);
        tick_n(39);
        check_pos("miss_pre", 550, 470);
        check("miss_pre_state", int'(state), 2);
        tick_n(1);
        check_pos("miss_hit", 556, 472);
        check("miss_hit_state", int'(state), 3);
        check("miss_hit_pulse", int'(miss), 1);
        cyc();
        check("miss_after_state", int'(state), 0);
        check("miss_after_pulse", int'(miss), 0);
        check_pos("miss_after", 316, 236);
        check("miss_after_dir_x", int'(dir_x), 0);
        check("miss_after_dir_y", int'(dir_y), 1);

        // Speed 0 at serve behaves as step 1
        do_serve(0);
        tick_n(4);
        tick_n(1);
        check_pos("speed0", 317, 235);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
